// File: rtl/serial_add_pkg.sv
// serial_add_pkg: shared types and default sizing for the serial adder
// sequencer (serial_add_seq) and its shift counter.
//   state_t    : sequencer state, 2-bit encoding
//   WIDTH_DEF  : default operand/sum width (serial length of the adder)
//   CNT_W_DEF  : default shift-counter width (2**CNT_W_DEF > WIDTH_DEF)
package serial_add_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int CNT_W_DEF = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/serial_add_seq_shift_counter.sv
// shift_counter: counts serial shift cycles for the adder sequencer.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-low reset (count -> 0)
//   clr  : synchronous clear (count -> 0), wins over en
//   en   : increment enable
//   tc   : terminal count, high while count == WIDTH-1
module shift_counter
    import serial_add_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + CNT_W'(1);
        end
    end

    assign tc = (count == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/serial_add_seq.sv
// serial_add_seq: sequencer in front of a WIDTH-bit bit-serial adder.
// Takes one operand pair over in_valid/in_ready, pulses adder_load for one
// cycle, waits WIDTH shift cycles, captures the adder's parallel sum and
// carry-out, and offers them over out_valid/out_ready. One add in flight.
// Ports:
//   clk, rst                     : clock; synchronous active-low reset
//   in_valid/in_ready            : operand handshake
//   in_a, in_b, in_cin           : operands and carry-in
//   adder_load                   : one-cycle load strobe to the adder
//   adder_a, adder_b, adder_cin  : registered operands to the adder
//   adder_sum, adder_cout        : parallel result from the adder
//   out_valid/out_ready          : result handshake
//   out_sum, out_cout            : captured result
//   out_ovf                      : signed overflow (only with SERIAL_ADD_OVF_EN)
//   busy                         : high whenever not IDLE
// Build option: define SERIAL_ADD_OVF_EN to add the out_ovf port and logic.
module serial_add_seq
    import serial_add_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             adder_load,
    output logic [WIDTH-1:0] adder_a,
    output logic [WIDTH-1:0] adder_b,
    output logic             adder_cin,
    input  logic [WIDTH-1:0] adder_sum,
    input  logic             adder_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
`ifdef SERIAL_ADD_OVF_EN
    output logic             out_ovf,
`endif
    output logic             busy
);

    state_t state;
    state_t next_state;
    logic   tc;
    logic   accept;
    logic   capture;

    assign accept  = (state == IDLE) && in_valid;
    // Last shift cycle: the adder's parallel output is complete at this edge.
    assign capture = (state == SHIFT) && tc;

    shift_counter #(
        .CNT_W (CNT_W),
        .WIDTH (WIDTH)
    ) u_cnt (
        .clk (clk),
        .rst (rst),
        .clr (state == LOAD),
        .en  (state == SHIFT),
        .tc  (tc)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            adder_a   <= '0;
            adder_b   <= '0;
            adder_cin <= 1'b0;
            out_sum   <= '0;
            out_cout  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            out_ovf   <= 1'b0;
`endif
        end else begin
            state <= next_state;
            if (accept) begin
                adder_a   <= in_a;
                adder_b   <= in_b;
                adder_cin <= in_cin;
            end
            if (capture) begin
                out_sum  <= adder_sum;
                out_cout <= adder_cout;
`ifdef SERIAL_ADD_OVF_EN
                out_ovf  <= (adder_a[WIDTH-1] == adder_b[WIDTH-1]) &&
                            (adder_sum[WIDTH-1] != adder_a[WIDTH-1]);
`endif
            end
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:  if (in_valid)  next_state = LOAD;
            LOAD:                 next_state = SHIFT;
            SHIFT: if (tc)        next_state = DONE;
            DONE:  if (out_ready) next_state = IDLE;
            default:              next_state = IDLE;
        endcase
    end

    // All handshake outputs decode straight from the registered state, so
    // in_ready only returns the cycle after the result handshake.
    assign in_ready   = (state == IDLE);
    assign adder_load = (state == LOAD);
    assign out_valid  = (state == DONE);
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_serial_add_seq.sv
// tb_serial_add_seq: directed + random checks of serial_add_seq against a
// behavioural serial-adder stub and an arithmetic reference.
module tb_serial_add_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         in_cin = 1'b0;
    logic         adder_load;
    logic [W-1:0] adder_a;
    logic [W-1:0] adder_b;
    logic         adder_cin;
    logic [W-1:0] adder_sum;
    logic         adder_cout;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_sum;
    logic         out_cout;
`ifdef SERIAL_ADD_OVF_EN
    logic         out_ovf;
`endif
    logic         busy;

    int passed = 0;
    int fails  = 0;
    int total  = 0;

    always #5 clk = ~clk;

    serial_add_seq dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_cin     (in_cin),
        .adder_load (adder_load),
        .adder_a    (adder_a),
        .adder_b    (adder_b),
        .adder_cin  (adder_cin),
        .adder_sum  (adder_sum),
        .adder_cout (adder_cout),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sum    (out_sum),
        .out_cout   (out_cout),
`ifdef SERIAL_ADD_OVF_EN
        .out_ovf    (out_ovf),
`endif
        .busy       (busy)
    );

    // Serial adder stub: latches operands on load, then needs W shift cycles
    // (the load-following cycle being the first) before its parallel output
    // is right; until then it shows the complement so an early capture shows.
    logic [W-1:0] ma, mb;
    logic         mc;
    logic         loaded;
    int           nsh;
    logic [W:0]   full;

    always @(posedge clk) begin
        if (!rst) begin
            loaded <= 1'b0;
            nsh    <= 0;
        end else if (adder_load) begin
            ma     <= adder_a;
            mb     <= adder_b;
            mc     <= adder_cin;
            loaded <= 1'b1;
            nsh    <= 0;
        end else if (loaded && nsh < W) begin
            nsh <= nsh + 1;
        end
    end

    assign full       = {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mc};
    assign adder_sum  = (loaded && nsh >= W - 1) ? full[W-1:0] : ~full[W-1:0];
    assign adder_cout = (loaded && nsh >= W - 1) ? full[W] : ~full[W];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full transaction. bp: cycles of out_ready=0 after out_valid.
    // junk: hold in_valid high with 0x11/0x22 while the add is in flight.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input int bp, input bit junk);
        int         k;
        int         lat;
        int         loads;
        int         ea, eb, er;
        logic [W:0] exp_full;
        logic [W-1:0] hs;
        logic       hc;
        exp_full = W'(a) + W'(b) + cin;
        exp_full = (W + 1)'(int'(a) + int'(b) + int'(cin));
        k = 0;
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("in_ready_wait", in_ready, 1);
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_cin = cin;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("adder_a", adder_a, a);
        chk("adder_b", adder_b, b);
        chk("adder_cin", adder_cin, cin);
        chk("load_t1", adder_load, 1);
        chk("busy_t1", busy, 1);
        chk("in_ready_t1", in_ready, 0);
        if (junk) begin
            in_valid = 1'b1;
            in_a = 8'h11;
            in_b = 8'h22;
            in_cin = 1'b0;
        end
        lat = 1;
        loads = 0;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
            loads += int'(adder_load);
            if (junk) begin
                chk("hold_a", adder_a, a);
                chk("hold_b", adder_b, b);
                chk("busy_ready", in_ready, 0);
            end
        end
        chk("latency", lat, W + 2);
        chk("load_once", loads, 0);
        hs = out_sum;
        hc = out_cout;
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            chk("bp_valid", out_valid, 1);
            chk("bp_sum", out_sum, hs);
            chk("bp_cout", out_cout, hc);
            chk("bp_in_ready", in_ready, 0);
        end
        chk("out_sum", out_sum, exp_full[W-1:0]);
        chk("out_cout", out_cout, exp_full[W]);
`ifdef SERIAL_ADD_OVF_EN
        ea = (a >= 128) ? int'(a) - 256 : int'(a);
        eb = (b >= 128) ? int'(b) - 256 : int'(b);
        er = ea + eb + int'(cin);
        chk("out_ovf", out_ovf, (er > 127 || er < -128) ? 1 : 0);
`else
        ea = 0;
        eb = 0;
        er = 0;
`endif
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("valid_drop", out_valid, 0);
        chk("in_ready_back", in_ready, 1);
        chk("busy_idle", busy, 0);
        if (junk) chk("junk_not_taken", adder_a, a);
    endtask

    initial begin
        int seen;
        // Reset state
        rst = 1'b0;
        out_ready = 1'b1;  // out_ready with no result pending must be harmless
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_load", adder_load, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sum", out_sum, 0);
        chk("rst_cout", out_cout, 0);
        chk("rst_adder_a", adder_a, 0);
        chk("rst_adder_b", adder_b, 0);
        chk("rst_adder_cin", adder_cin, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_valid", out_valid, 0);
        out_ready = 1'b0;

        // Basic add and carry wrap
        run_op(8'h5A, 8'h33, 1'b0, 0, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0, 0, 1'b0);
        run_op(8'hFF, 8'hFF, 1'b1, 0, 1'b0);

        // Backpressure for 5 cycles
        run_op(8'hC3, 8'h7E, 1'b1, 5, 1'b0);

        // Busy rejection, then the held request is taken once ready returns
        run_op(8'h40, 8'h05, 1'b0, 2, 1'b1);
        run_op(8'h11, 8'h22, 1'b0, 0, 1'b0);

        // Reset during shift cycle 4
        in_valid = 1'b1;
        in_a = 8'h9C;
        in_b = 8'h4D;
        in_cin = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("pre_rst_busy", busy, 1);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_sum", out_sum, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_adder_a", adder_a, 0);
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            seen += int'(out_valid);
        end
        chk("no_stale_result", seen, 0);
        run_op(8'h01, 8'h02, 1'b0, 0, 1'b0);

        // Signed-overflow corners (flag checked only when built in)
        run_op(8'h7F, 8'h01, 1'b0, 0, 1'b0);
        run_op(8'h80, 8'h80, 1'b0, 0, 1'b0);
        run_op(8'h10, 8'h20, 1'b0, 0, 1'b0);

        // Random traffic
        for (int n = 0; n < 20; n++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)), 1'b0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/serial_add_seq.md
Name: serial_add_seq

Overview:
- Sequencer directly upstream of the 8-bit bit-serial adder.
- Accepts an operand pair over a valid/ready handshake and drives the adder's load strobe and operand/carry inputs.
- Counts the serial shift cycles, captures the parallel sum and carry-out, and presents the result downstream over a second valid/ready handshake.
- Handles one addition at a time; no internal queueing.

Parameters:
- WIDTH, 8, operand/sum width; equals the adder's serial length; legal range 2..32.
- CNT_W, 6, shift-counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-low reset; sampled on rising clk edge.
- in_valid  input  1  operand pair available.
- in_ready  output  1  block can accept operands.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_cin  input  1  carry-in.
- adder_load  output  1  one-cycle load strobe to the serial adder.
- adder_a  output  WIDTH  operand A to the adder (registered).
- adder_b  output  WIDTH  operand B to the adder (registered).
- adder_cin  output  1  carry-in to the adder (registered).
- adder_sum  input  WIDTH  parallel sum from the adder.
- adder_cout  input  1  carry-out from the adder.
- out_valid  output  1  result held and valid.
- out_ready  input  1  downstream accepts the result.
- out_sum  output  WIDTH  captured sum.
- out_cout  output  1  captured carry-out.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (rst=0 at a clk edge):
  - State goes to IDLE; shift counter cleared.
  - in_ready=1, adder_load=0, out_valid=0, busy=0.
  - out_sum, out_cout, adder_a, adder_b and adder_cin all 0.
- States: IDLE, LOAD, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready at edge T: register in_a, in_b, in_cin onto adder_a, adder_b, adder_cin; go to LOAD.
- LOAD:
  - adder_load=1 for exactly cycle T+1.
  - Counter cleared; go to SHIFT.
- SHIFT:
  - adder_load=0; counter increments each cycle.
  - After WIDTH cycles (counter==WIDTH-1 at the edge), capture adder_sum into out_sum and adder_cout into out_cout; go to DONE.
- DONE:
  - out_valid=1 from cycle T+2+WIDTH.
  - out_sum/out_cout stay stable while out_valid=1 and out_ready=0.
  - On out_valid&out_ready: drop out_valid, go to IDLE.
  - in_ready rises the cycle after the output handshake, so there is no same-cycle back-to-back acceptance.
- Latency: input handshake to out_valid = WIDTH+2 cycles (10 for WIDTH=8). Minimum issue interval = WIDTH+3 cycles.
- in_ready=0 in LOAD, SHIFT and DONE. in_valid in those states is ignored and the operands are not consumed.
- adder_a, adder_b and adder_cin hold their values from IDLE-accept until the next accept.
- Reset mid-operation (any state): immediate return to IDLE with reset values.
  - Any partial result is discarded; out_valid is never asserted for the aborted operation.
- out_ready high while out_valid=0: no effect.
- Sum width: WIDTH bits. Carry beyond the MSB is reported only via out_cout. No saturation.

Optional Feature:
- Macro SERIAL_ADD_OVF_EN.
- Defined:
  - Adds output port out_ovf (1 bit), the two's-complement signed overflow flag.
  - out_ovf = (adder_a[MSB]==adder_b[MSB]) && (adder_sum[MSB]!=adder_a[MSB]).
  - Captured in the same SHIFT→DONE transition as out_sum and held identically.
  - Reset value 0.
- Undefined: port absent; no overflow logic.

Decomposition:
- Package serial_add_pkg holds:
  - state enum (IDLE, LOAD, SHIFT, DONE), 2-bit encoding;
  - default WIDTH constant;
  - CNT_W constant.
- One natural sub-module: shift_counter, a CNT_W-bit counter with synchronous active-low reset, clear and enable, and a terminal-count output at WIDTH-1.
- FSM, operand registers and result registers stay in serial_add_seq.

Test Plan:
- Basic add: in_a=0x5A, in_b=0x33, in_cin=0, behavioural serial-adder model attached.
  -> adder_load high exactly 1 cycle, 1 cycle after accept; out_valid 10 cycles after accept; out_sum=0x8D, out_cout=0.
- Carry wrap: 0xFF+0x01, cin=0 -> out_sum=0x00, out_cout=1. Then 0xFF+0xFF, cin=1 -> out_sum=0xFF, out_cout=1.
- Backpressure: out_ready held 0 for 5 cycles after out_valid -> out_valid, out_sum and out_cout stable all 5 cycles; in_ready=0 throughout; IDLE one cycle after out_ready=1.
- Busy rejection: in_valid held 1 with new operands (0x11, 0x22) during SHIFT -> no accept, adder_a/adder_b unchanged; operands accepted only once in_ready returns to 1.
- Reset mid-SHIFT: rst=0 at shift cycle 4 -> next cycle state IDLE, in_ready=1, out_valid=0, out_sum=0; no stale result delivered. A subsequent 0x01+0x02 returns 0x03.
- SERIAL_ADD_OVF_EN defined:
  - 0x7F+0x01 -> out_sum=0x80, out_ovf=1, out_cout=0;
  - 0x80+0x80 -> out_sum=0x00, out_ovf=1, out_cout=1;
  - 0x10+0x20 -> out_ovf=0.
